// File: rtl/mips_mem_pkg.sv
// Shared definitions for the sub-word memory access unit.
package mips_mem_pkg;

   localparam int DEPTH_LOG2_DEF = 8;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // A request is usable only with exactly one of read/write and natural alignment.
   function automatic logic req_legal(input logic rd, input logic wr,
                                      input logic [1:0] sz, input logic [1:0] lsb);
      logic ok;
      ok = (rd ^ wr);
      if (sz == 2'b11)                       ok = 1'b0;
      if (sz == SZ_HALF && lsb[0])           ok = 1'b0;
      if (sz == SZ_WORD && lsb != 2'b00)     ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and store lane merge.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] load_word,
   input  logic [31:0] store_old,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] merged_word
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Pick the addressed lane and extend it to a full word.
   always_comb begin
      lane_byte  = load_word[{offset, 3'b000} +: 8];
      lane_half  = load_word[{offset[1], 4'b0000} +: 16];
      load_value = load_word;
      case (size)
         SZ_BYTE: load_value = {{24{~is_unsigned & lane_byte[7]}}, lane_byte};
         SZ_HALF: load_value = {{16{~is_unsigned & lane_half[15]}}, lane_half};
         default: load_value = load_word;
      endcase
   end

   // Replace only the addressed lane(s) of the old word; word stores pass through.
   always_comb begin
      merged_word = store_old;
      case (size)
         SZ_BYTE: merged_word[{offset, 3'b000} +: 8]     = store_data[7:0];
         SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
         default: merged_word = store_data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer in front of a word-only data memory.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; rejects illegal requests with err
//   RD      | mem_read, capture word (load result or RMW buffer)
//   WR      | mem_write of merged (sub-word) or raw (word) store data
//   DONE    | done pulse, then back to IDLE
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata,
   output logic [31:0] Load_Data,
   output logic        done,
   output logic        busy,
   output logic        err
);

   state_t                  state;
   logic [DEPTH_LOG2+1:0]   addr_q;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic                    store_q;
   logic [31:0]             wdata_q;
   logic [31:0]             buf_q;
   logic                    rd_q;
   logic                    wr_q;
   logic [31:0]             load_value;

   // Upper address bits never reach the memory; the index wraps.
   logic unused_addr_bits;
   assign unused_addr_bits = ^Address[31:DEPTH_LOG2+2];

   assign mem_addr  = {{(32-DEPTH_LOG2){1'b0}}, addr_q[DEPTH_LOG2+1:2]};
   assign mem_read  = rd_q;
   assign mem_write = wr_q & ~reset;

   mem_lane_align u_align (
      .size        (size_q),
      .offset      (addr_q[1:0]),
      .is_unsigned (uns_q),
      .load_word   (mem_rdata),
      .store_old   (buf_q),
      .store_data  (wdata_q),
      .load_value  (load_value),
      .merged_word (mem_wdata)
   );

   // Sequencer with registered strobes; reset aborts any in-flight access.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         store_q   <= 1'b0;
         wdata_q   <= '0;
         buf_q     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         Load_Data <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  addr_q  <= Address[DEPTH_LOG2+1:0];
                  size_q  <= size;
                  uns_q   <= is_unsigned;
                  store_q <= MemWrite;
                  wdata_q <= Write_Data;
                  if (!req_legal(MemRead, MemWrite, size, Address[1:0])) begin
                     err <= 1'b1;
                  end else if (MemWrite && size == SZ_WORD) begin
                     state <= ST_WR;
                     wr_q  <= 1'b1;
                     busy  <= 1'b1;
                  end else begin
                     state <= ST_RD;
                     rd_q  <= 1'b1;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               buf_q <= mem_rdata;
               rd_q  <= 1'b0;
               if (store_q) begin
                  state <= ST_WR;
                  wr_q  <= 1'b1;
               end else begin
                  Load_Data <= load_value;
                  state     <= ST_DONE;
                  done      <= 1'b1;
               end
            end
            ST_WR: begin
               wr_q  <= 1'b0;
               state <= ST_DONE;
               done  <= 1'b1;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed cases then random requests against a word-array model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  size;
   logic        is_unsigned;
   logic [31:0] Address;
   logic [31:0] Write_Data;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic [31:0] Load_Data;
   logic        done;
   logic        busy;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] ref_load = 32'h0;

   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = 8'h0;
   logic [31:0] pre_val = 32'h0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .size        (size),
      .is_unsigned (is_unsigned),
      .Address     (Address),
      .Write_Data  (Write_Data),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_rdata   (mem_rdata),
      .Load_Data   (Load_Data),
      .done        (done),
      .busy        (busy),
      .err         (err)
   );

   assign mem_rdata = mem[mem_addr[7:0]];

   always @(posedge clk) begin
      if (mem_write)   mem[mem_addr[7:0]] <= mem_wdata;
      else if (pre_en) mem[pre_idx] <= pre_val;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] off);
      logic [31:0] v;
      case (sz)
         2'd0: begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
         end
         2'd1: begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] mask;
      int          sh;
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
      sh   = (sz == 2'd2) ? 0 : 8 * off;
      return (old & ~(mask << sh)) | ((wd & mask) << sh);
   endfunction

   // One request from the start cycle to the first idle cycle after it.
   task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold_start);
      bit          legal;
      int          idx;
      int          lat;
      logic [1:0]  off;
      logic [31:0] exp_ld;
      logic [31:0] exp_wd;
      bit          e_rd, e_wr, e_done;
      legal = (rd != wr) && (sz != 2'd3) && !(sz == 2'd1 && addr[0])
              && !(sz == 2'd2 && addr[1:0] != 2'd0);
      idx    = int'(addr[9:2]);
      off    = addr[1:0];
      exp_ld = model_load(ref_mem[idx], sz, uns, off);
      exp_wd = model_store(ref_mem[idx], wd, sz, off);
      lat    = !legal ? 1 : (rd || sz == 2'd2) ? 2 : 3;

      @(negedge clk);
      start = 1'b1; MemRead = rd; MemWrite = wr; size = sz;
      is_unsigned = uns; Address = addr; Write_Data = wd;
      @(negedge clk);
      if (!hold_start || !legal) start = 1'b0;
      Address = $urandom; Write_Data = $urandom; size = 2'($urandom_range(0, 3));
      is_unsigned = 1'($urandom_range(0, 1));
      MemRead = 1'($urandom_range(0, 1)); MemWrite = 1'($urandom_range(0, 1));
      for (int c = 1; c <= lat; c++) begin
         if (c > 1) @(negedge clk);
         e_rd   = legal && c == 1 && (rd || sz != 2'd2);
         e_wr   = legal && wr && ((sz == 2'd2 && c == 1) || (sz != 2'd2 && c == 2));
         e_done = legal && c == lat;
         check($sformatf("mem_read c%0d", c),  {31'b0, mem_read},  {31'b0, e_rd});
         check($sformatf("mem_write c%0d", c), {31'b0, mem_write}, {31'b0, e_wr});
         check($sformatf("done c%0d", c),      {31'b0, done},      {31'b0, e_done});
         check($sformatf("busy c%0d", c),      {31'b0, busy},      {31'b0, legal});
         check($sformatf("err c%0d", c),       {31'b0, err},       {31'b0, !legal && c == 1});
         if (e_rd || e_wr) check($sformatf("mem_addr c%0d", c), mem_addr, 32'(idx));
         if (e_wr)         check("mem_wdata", mem_wdata, exp_wd);
         if (e_done)       check("Load_Data done", Load_Data, rd ? exp_ld : ref_load);
      end
      if (legal && rd) ref_load = exp_ld;
      if (legal && wr) ref_mem[idx] = exp_wd;
      start = 1'b0;
      @(negedge clk);
      check("idle busy",  {31'b0, busy},  32'h0);
      check("idle done",  {31'b0, done},  32'h0);
      check("idle err",   {31'b0, err},   32'h0);
      check("idle rdwr",  {30'b0, mem_read, mem_write}, 32'h0);
      check("idle Load_Data", Load_Data, ref_load);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; size = 2'd0;
      is_unsigned = 1'b0; Address = 32'h0; Write_Data = 32'h0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = (i == 7) ? 32'd7 : $urandom;
         @(negedge clk);
         pre_en = 1'b1; pre_idx = 8'(i); pre_val = ref_mem[i];
      end
      @(negedge clk);
      pre_en = 1'b0;
      @(negedge clk);
      check("reset mem_write", {31'b0, mem_write}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'h0);
      check("reset done/err", {30'b0, done, err}, 32'h0);
      check("reset mem_read", {31'b0, mem_read}, 32'h0);
      check("reset Load_Data", Load_Data, 32'h0);

      run_req(1, 0, 2'd2, 0, 32'd28, 32'h0, 1);
      check("lw word7", Load_Data, 32'h00000007);
      run_req(0, 1, 2'd2, 0, 32'd12, 32'h123480F0, 1);
      run_req(1, 0, 2'd0, 0, 32'd12, 32'h0, 0);
      check("lb @12", Load_Data, 32'hFFFFFFF0);
      run_req(1, 0, 2'd0, 1, 32'd13, 32'h0, 1);
      check("lbu @13", Load_Data, 32'h00000080);
      run_req(1, 0, 2'd1, 0, 32'd14, 32'h0, 0);
      check("lh @14", Load_Data, 32'h00001234);
      run_req(1, 0, 2'd1, 1, 32'd12, 32'h0, 1);
      check("lhu @12", Load_Data, 32'h000080F0);
      run_req(0, 1, 2'd0, 0, 32'd13, 32'h000000AB, 1);
      run_req(1, 0, 2'd2, 0, 32'd12, 32'h0, 0);
      check("lw after sb", Load_Data, 32'h1234ABF0);
      run_req(1, 0, 2'd2, 0, 32'd6, 32'h0, 0);
      run_req(0, 1, 2'd1, 0, 32'd13, 32'h5555, 0);
      run_req(1, 1, 2'd2, 0, 32'd12, 32'h0, 0);
      run_req(0, 0, 2'd0, 0, 32'd12, 32'h0, 0);
      run_req(1, 0, 2'd3, 0, 32'd12, 32'h0, 0);

      // Reset during the read phase of a byte store must abort with no write.
      @(negedge clk);
      start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; size = 2'd0;
      Address = 32'd13; Write_Data = 32'h00000055;
      @(negedge clk);
      start = 1'b0;
      check("abort RD mem_read", {31'b0, mem_read}, 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check("abort mem_write in reset", {31'b0, mem_write}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      ref_load = 32'h0;
      check("abort busy", {31'b0, busy}, 32'h0);
      check("abort done", {31'b0, done}, 32'h0);
      check("abort mem_write", {31'b0, mem_write}, 32'h0);
      check("abort Load_Data", Load_Data, 32'h0);
      run_req(1, 0, 2'd2, 0, 32'd12, 32'h0, 0);
      check("word3 unchanged", Load_Data, 32'h1234ABF0);

      for (int n = 0; n < 200; n++) begin
         logic        r_rd, r_wr, r_uns;
         logic [1:0]  r_sz;
         logic [31:0] r_addr;
         if ($urandom_range(0, 9) < 8) begin
            r_rd = 1'($urandom_range(0, 1)); r_wr = ~r_rd;
         end else begin
            r_rd = 1'($urandom_range(0, 1)); r_wr = r_rd;
         end
         r_sz   = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
         r_uns  = 1'($urandom_range(0, 1));
         r_addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) r_addr = r_addr | ($urandom & 32'hFFFFFC00);
         run_req(r_rd, r_wr, r_sz, r_uns, r_addr, $urandom, bit'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
